// File: rtl/complex_scale_pipe_if.sv
// complex_scale_pipe_if: sample stream into and out of complex_scale_pipe.
// slave is the scaler's view, master the producer/consumer view.
interface complex_scale_pipe_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NFFT       = 128,
    parameter int SHIFT_W    = $clog2(NFFT) + 1
);
    logic                          in_valid;
    logic                          in_ready;
    logic signed [DATA_WIDTH-1:0]  data_in_r;
    logic signed [DATA_WIDTH-1:0]  data_in_i;
    logic [SHIFT_W-1:0]            shift_mag;
    logic                          shift_dir;
    logic                          out_valid;
    logic                          out_ready;
    logic signed [DATA_WIDTH-1:0]  data_out_r;
    logic signed [DATA_WIDTH-1:0]  data_out_i;
    logic                          ovf_flag;
    logic                          frame_done;
    logic [$clog2(NFFT)-1:0]       sample_cnt;

    modport slave (
        input  in_valid, data_in_r, data_in_i, shift_mag, shift_dir, out_ready,
        output in_ready, out_valid, data_out_r, data_out_i, ovf_flag,
        output frame_done, sample_cnt
    );

    modport master (
        output in_valid, data_in_r, data_in_i, shift_mag, shift_dir, out_ready,
        input  in_ready, out_valid, data_out_r, data_out_i, ovf_flag,
        input  frame_done, sample_cnt
    );
endinterface

// File: rtl/complex_scale_pipe.sv
// complex_scale_pipe: 2-stage complex shift/saturate with frame tracking.
// Define CSCALE_ROUND_EN for round-half-up right shifts (default: truncate).
module complex_scale_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int NFFT       = 128,
    parameter int SHIFT_W    = $clog2(NFFT) + 1
) (
    input  logic                clk,
    input  logic                rst,
    complex_scale_pipe_if.slave bus
);
    localparam int DW = DATA_WIDTH;
    localparam int CW = $clog2(NFFT);
    localparam logic [31:0] DWU = DW;
    localparam logic signed [DW-1:0]   MAXV = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0]   MINV = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [2*DW-1:0] MAXW = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [2*DW-1:0] MINW = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};
`ifdef CSCALE_ROUND_EN
    localparam logic signed [DW:0]     MAXE = {2'b00, {(DW-1){1'b1}}};
`endif

    // Returns {saturated, result} for one component.
    function automatic logic [DW:0] scale(
        input logic signed [DW-1:0] x,
        input logic [SHIFT_W-1:0]   s,
        input logic                 dir
    );
        logic signed [DW-1:0]   res;
        logic signed [2*DW-1:0] wide;
        logic                   sat;
        logic                   big;
`ifdef CSCALE_ROUND_EN
        logic signed [DW:0]     sum;
        sum  = '0;
`endif
        res  = x;
        sat  = 1'b0;
        wide = '0;
        big  = 32'(s) >= DWU;
        if (s == '0) begin
            res = x;
        end else if (!dir) begin
            if (big) begin
                res = '0;
            end else begin
`ifdef CSCALE_ROUND_EN
                sum = {x[DW-1], x} + ({{DW{1'b0}}, 1'b1} << (s - SHIFT_W'(1)));
                sum = sum >>> s;
                if (sum > MAXE) begin
                    res = MAXV;
                    sat = 1'b1;
                end else begin
                    res = sum[DW-1:0];
                end
`else
                res = x >>> s;
`endif
            end
        end else if (big) begin
            sat = x != '0;
            res = (x == '0) ? '0 : (x[DW-1] ? MINV : MAXV);
        end else begin
            wide = (2*DW)'(x) <<< s;
            if (wide > MAXW) begin
                res = MAXV;
                sat = 1'b1;
            end else if (wide < MINW) begin
                res = MINV;
                sat = 1'b1;
            end else begin
                res = wide[DW-1:0];
            end
        end
        return {sat, res};
    endfunction

    logic                 s1_valid;
    logic signed [DW-1:0] s1_r;
    logic signed [DW-1:0] s1_i;
    logic [SHIFT_W-1:0]   s1_mag;
    logic                 s1_dir;
    logic                 o_valid;
    logic signed [DW-1:0] o_r;
    logic signed [DW-1:0] o_i;
    logic                 ovf;
    logic [CW-1:0]        cnt;
    logic [DW:0]          sc_r;
    logic [DW:0]          sc_i;
    logic                 adv;
    logic                 in_rdy;
    logic                 in_fire;
    logic                 out_fire;
    logic                 last;
    logic                 load2;

    assign sc_r     = scale(s1_r, s1_mag, s1_dir);
    assign sc_i     = scale(s1_i, s1_mag, s1_dir);
    assign adv      = !o_valid || bus.out_ready;
    assign in_rdy   = !s1_valid || adv;
    assign in_fire  = bus.in_valid && in_rdy;
    assign out_fire = o_valid && bus.out_ready;
    assign last     = &cnt;
    assign load2    = adv && s1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
            s1_i     <= '0;
            s1_mag   <= '0;
            s1_dir   <= 1'b0;
            o_valid  <= 1'b0;
            o_r      <= '0;
            o_i      <= '0;
            ovf      <= 1'b0;
            cnt      <= '0;
        end else begin
            if (in_rdy) s1_valid <= bus.in_valid;
            if (in_fire) begin
                s1_r   <= bus.data_in_r;
                s1_i   <= bus.data_in_i;
                s1_mag <= bus.shift_mag;
                s1_dir <= bus.shift_dir;
            end
            if (adv) o_valid <= s1_valid;
            if (load2) begin
                o_r <= sc_r[DW-1:0];
                o_i <= sc_i[DW-1:0];
            end
            if (out_fire) cnt <= cnt + CW'(1);
            // A saturating first sample of the next frame wins over the clear.
            ovf <= (ovf && !(out_fire && last)) ||
                   (load2 && (sc_r[DW] || sc_i[DW]));
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.out_valid  = o_valid;
    assign bus.data_out_r = o_r;
    assign bus.data_out_i = o_i;
    assign bus.ovf_flag   = ovf;
    assign bus.frame_done = o_valid && last;
    assign bus.sample_cnt = cnt;
endmodule

// File: tb/tb_complex_scale_pipe.sv
// tb_complex_scale_pipe: directed checks of scaling, handshake and framing.
`timescale 1ns/1ps
module tb_complex_scale_pipe;
    localparam int DW   = 16;
    localparam int NFFT = 128;
    localparam int SW   = $clog2(NFFT) + 1;
    localparam int CW   = $clog2(NFFT);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;

    typedef struct {
        logic signed [DW-1:0] r;
        logic signed [DW-1:0] i;
        logic [CW-1:0]        cnt;
        logic                 fd;
        logic                 ovf;
        int                   cyc;
    } beat_t;
    beat_t q[$];

    typedef struct {
        int r, i, m, d, er, ei, eo;
    } vec_t;

    complex_scale_pipe_if #(.DATA_WIDTH(DW), .NFFT(NFFT), .SHIFT_W(SW)) bus();

    complex_scale_pipe #(.DATA_WIDTH(DW), .NFFT(NFFT), .SHIFT_W(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (!rst && bus.out_valid && bus.out_ready)
            q.push_back('{bus.data_out_r, bus.data_out_i, bus.sample_cnt,
                          bus.frame_done, bus.ovf_flag, cyc});

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        rst = 1'b0;
    endtask

    task automatic send(input logic signed [DW-1:0] r, input logic signed [DW-1:0] i,
                        input logic [SW-1:0] m, input logic d);
        bit acc = 1'b0;
        bus.in_valid  = 1'b1;
        bus.data_in_r = r;
        bus.data_in_i = i;
        bus.shift_mag = m;
        bus.shift_dir = d;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (q.size() < n && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (q.size() < n) begin
            checks++;
            errors++;
            $display("FAIL wait_out: got %0d beats, expected %0d", q.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks += 6;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b expected 1", bus.in_ready); end
        if (bus.ovf_flag !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", bus.ovf_flag); end
        if (bus.sample_cnt !== '0) begin errors++; $display("FAIL rst_cnt: got %0d expected 0", bus.sample_cnt); end
        if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b expected 0", bus.frame_done); end
        if (bus.data_out_r !== '0 || bus.data_out_i !== '0) begin
            errors++;
            $display("FAIL rst_data: got %0d,%0d expected 0,0", bus.data_out_r, bus.data_out_i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_scaling();
        vec_t tbl[11];
        logic signed [DW-1:0] er, ei;
        tbl[0]  = '{100, -100, 2, 0, 25, -25, 0};
`ifdef CSCALE_ROUND_EN
        tbl[1]  = '{32767, -3, 1, 0, 16384, -1, 0};
        tbl[2]  = '{-7, 7, 1, 0, -3, 4, 0};
        tbl[9]  = '{1, -1, 15, 0, 0, 0, 0};
`else
        tbl[1]  = '{32767, -3, 1, 0, 16383, -2, 0};
        tbl[2]  = '{-7, 7, 1, 0, -4, 3, 0};
        tbl[9]  = '{1, -1, 15, 0, 0, -1, 0};
`endif
        tbl[3]  = '{-5, 7, 16, 0, 0, 0, 0};
        tbl[4]  = '{-32768, 12345, 0, 1, -32768, 12345, 0};
        tbl[5]  = '{4096, -4096, 4, 1, 32767, -32768, 1};
        tbl[6]  = '{-16384, 16383, 1, 1, -32768, 32766, 0};
        tbl[7]  = '{0, 3, 20, 1, 0, 32767, 1};
        tbl[8]  = '{-3, 5, 3, 1, -24, 40, 0};
        tbl[10] = '{123, -456, 0, 0, 123, -456, 0};
        for (int k = 0; k < 11; k++) begin
            do_reset();
            send(DW'(tbl[k].r), DW'(tbl[k].i), SW'(tbl[k].m), tbl[k].d[0]);
            wait_out(1);
            if (q.size() > 0) begin
                er = DW'(tbl[k].er);
                ei = DW'(tbl[k].ei);
                checks += 4;
                if (q[0].r !== er) begin errors++; $display("FAIL vec%0d_real: got %0d expected %0d", k, q[0].r, er); end
                if (q[0].i !== ei) begin errors++; $display("FAIL vec%0d_imag: got %0d expected %0d", k, q[0].i, ei); end
                if (q[0].ovf !== tbl[k].eo[0]) begin errors++; $display("FAIL vec%0d_ovf: got %b expected %0d", k, q[0].ovf, tbl[k].eo); end
                if (q[0].cyc - acc_cyc != 2) begin errors++; $display("FAIL vec%0d_latency: got %0d expected 2", k, q[0].cyc - acc_cyc); end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.out_ready = 1'b0;
        send(10, -10, 0, 0);
        send(20, -20, 0, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks += 4;
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d: got %b expected 0", k, bus.in_ready); end
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid%0d: got %b expected 1", k, bus.out_valid); end
            if (bus.data_out_r !== 16'sd10) begin errors++; $display("FAIL bp_hold%0d: got %0d expected 10", k, bus.data_out_r); end
            if (bus.sample_cnt !== '0) begin errors++; $display("FAIL bp_cnt%0d: got %0d expected 0", k, bus.sample_cnt); end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        send(30, -30, 0, 0);
        send(40, -40, 0, 0);
        wait_out(4);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d beats expected 4", q.size()); end
        for (int k = 0; k < 4 && k < q.size(); k++) begin
            checks += 2;
            if (q[k].r !== DW'(10 * (k + 1))) begin errors++; $display("FAIL bp_order%0d: got %0d expected %0d", k, q[k].r, 10 * (k + 1)); end
            if (q[k].cnt !== CW'(k)) begin errors++; $display("FAIL bp_beat_cnt%0d: got %0d expected %0d", k, q[k].cnt, k); end
        end
    endtask

    task automatic test_frame();
        int nfd = 0;
        do_reset();
        for (int k = 0; k < 130; k++) begin
            if (k == 0 || k == 128) send(16384, 0, 1, 1);
            else send(DW'(k), 0, 0, 1);
        end
        wait_out(130);
        if (q.size() >= 130) begin
            foreach (q[k]) if (q[k].fd) nfd++;
            checks += 8;
            if (nfd != 1) begin errors++; $display("FAIL frame_done_count: got %0d expected 1", nfd); end
            if (q[127].fd !== 1'b1) begin errors++; $display("FAIL frame_done_beat128: got %b expected 1", q[127].fd); end
            if (q[127].cnt !== CW'(127)) begin errors++; $display("FAIL frame_cnt127: got %0d expected 127", q[127].cnt); end
            if (q[129].cnt !== CW'(1)) begin errors++; $display("FAIL frame_cnt_beat130: got %0d expected 1", q[129].cnt); end
            if (q[127].ovf !== 1'b1) begin errors++; $display("FAIL frame_ovf_last: got %b expected 1", q[127].ovf); end
            if (q[128].ovf !== 1'b1 || q[128].r !== 16'sd32767) begin
                errors++;
                $display("FAIL frame_ovf_next: got %b,%0d expected 1,32767", q[128].ovf, q[128].r);
            end
            if (q[129].r !== 16'sd129) begin errors++; $display("FAIL frame_data130: got %0d expected 129", q[129].r); end
            if (q[129].cyc - q[0].cyc != 129) begin errors++; $display("FAIL frame_rate: got %0d cycles expected 129", q[129].cyc - q[0].cyc); end
        end
    endtask

    task automatic test_ovf_clear();
        do_reset();
        send(4096, -4096, 4, 1);
        for (int k = 1; k < 128; k++) send(DW'(k), DW'(-k), 0, 0);
        wait_out(128);
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (q.size() >= 128) begin
            checks += 4;
            if (q[0].ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", q[0].ovf); end
            if (q[64].ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", q[64].ovf); end
            if (q[127].ovf !== 1'b1 || q[127].fd !== 1'b1) begin
                errors++;
                $display("FAIL ovf_last_beat: got ovf %b fd %b expected 1 1", q[127].ovf, q[127].fd);
            end
            if (bus.ovf_flag !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.ovf_flag); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 5; k++) send(DW'(k + 1), 0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.sample_cnt !== CW'(3)) begin errors++; $display("FAIL mid_cnt_pre: got %0d expected 3", bus.sample_cnt); end
        #1 rst = 1'b1;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.sample_cnt !== '0) begin errors++; $display("FAIL mid_cnt: got %0d expected 0", bus.sample_cnt); end
        if (bus.ovf_flag !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", bus.ovf_flag); end
        @(posedge clk);
        #1;
        q.delete();
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", bus.in_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_drained: got %b expected 0", bus.out_valid); end
        @(posedge clk);
        #1;
        send(77, -77, 0, 0);
        wait_out(1);
        if (q.size() > 0) begin
            checks += 2;
            if (q[0].r !== 16'sd77) begin errors++; $display("FAIL mid_restart_data: got %0d expected 77", q[0].r); end
            if (q[0].cnt !== '0) begin errors++; $display("FAIL mid_restart_cnt: got %0d expected 0", q[0].cnt); end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.data_in_r = '0;
        bus.data_in_i = '0;
        bus.shift_mag = '0;
        bus.shift_dir = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_scaling();
        test_backpressure();
        test_frame();
        test_ovf_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
